// File: rtl/matrix_permute_engine.sv
// Sequential DIM x DIM bit-matrix permutation engine: captures a matrix on start,
// then moves LANES cells per cycle to their mapped position (transpose, rotations, mirror).
module matrix_permute_engine #(
  parameter int DIM   = 8,
  parameter int LANES = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [1:0]                    mode,
  input  logic [DIM*DIM-1:0]            matrix_in,
  output logic                          busy,
  output logic                          done,
  output logic [DIM*DIM-1:0]            matrix_out,
  output logic [$clog2(DIM*DIM)-1:0]    cnt,
  output logic [1:0]                    state_dbg
);

  localparam int W  = DIM * DIM;
  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - LANES);
  localparam logic [CW-1:0] STEP = CW'(LANES);

  generate
    if (LANES < 1 || (W % LANES) != 0) begin : g_bad_lanes
      $error("matrix_permute_engine: LANES must divide DIM*DIM");
    end
  endgenerate

  // Handshake: start is sampled only in IDLE; busy is high for the whole RUN
  // phase; done is a one-cycle pulse after which matrix_out holds the result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  logic [W-1:0]   src;
  logic [W-1:0]   dst;
  logic [W-1:0]   dst_next;
  logic [1:0]     mode_q;

  // Scatter the LANES cells starting at cnt into their mapped destinations.
  always_comb begin
    dst_next = dst;
    for (int l = 0; l < LANES; l++) begin
      int k;
      int r;
      int c;
      int nr;
      int nc;
      k  = int'(cnt) + l;
      r  = k / DIM;
      c  = k % DIM;
      nr = r;
      nc = c;
      case (mode_q)
        2'd0: begin nr = c;           nc = r;           end
        2'd1: begin nr = c;           nc = DIM - 1 - r; end
        2'd2: begin nr = DIM - 1 - r; nc = DIM - 1 - c; end
        default: begin nr = r;        nc = DIM - 1 - c; end
      endcase
      dst_next[CW'(nr * DIM + nc)] = src[CW'(k)];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      src    <= '0;
      dst    <= '0;
      cnt    <= '0;
      mode_q <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            src    <= matrix_in;
            mode_q <= mode;
            dst    <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          dst <= dst_next;
          if (cnt == LAST) begin
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + STEP;
          end
        end
        default: begin
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign matrix_out = dst;
  assign state_dbg  = state;

endmodule

// File: tb/tb_matrix_permute_engine.sv
// Randomized self-checking bench for matrix_permute_engine in three configurations
// (8x8/1 lane, 8x8/4 lanes, 5x5/5 lanes) against a grid-based reference model.
module tb_matrix_permute_engine;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        start_a, start_b, start_c;
  logic [1:0]  mode_a, mode_b, mode_c;
  logic [63:0] in_a, in_b, out_a, out_b;
  logic [24:0] in_c, out_c;
  logic        busy_a, busy_b, busy_c, done_a, done_b, done_c;
  logic [5:0]  cnt_a, cnt_b;
  logic [4:0]  cnt_c;
  logic [1:0]  st_a, st_b, st_c;

  matrix_permute_engine #(.DIM(8), .LANES(1)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .mode(mode_a), .matrix_in(in_a),
    .busy(busy_a), .done(done_a), .matrix_out(out_a), .cnt(cnt_a), .state_dbg(st_a));
  matrix_permute_engine #(.DIM(8), .LANES(4)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .mode(mode_b), .matrix_in(in_b),
    .busy(busy_b), .done(done_b), .matrix_out(out_b), .cnt(cnt_b), .state_dbg(st_b));
  matrix_permute_engine #(.DIM(5), .LANES(5)) u_c (
    .clk(clk), .rst(rst), .start(start_c), .mode(mode_c), .matrix_in(in_c),
    .busy(busy_c), .done(done_c), .matrix_out(out_c), .cnt(cnt_c), .state_dbg(st_c));

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Reference: lay the vector out as a grid, move every cell by the mapping rule.
  function automatic logic [63:0] model(input int dim, input int m, input logic [63:0] x);
    logic grid [8][8];
    logic [63:0] y;
    y = '0;
    for (int r = 0; r < dim; r++)
      for (int c = 0; c < dim; c++)
        grid[r][c] = x[r*dim + c];
    for (int r = 0; r < dim; r++) begin
      for (int c = 0; c < dim; c++) begin
        int nr;
        int nc;
        case (m)
          0: begin nr = c;           nc = r;           end
          1: begin nr = c;           nc = dim - 1 - r; end
          2: begin nr = dim - 1 - r; nc = dim - 1 - c; end
          default: begin nr = r;     nc = dim - 1 - c; end
        endcase
        y[nr*dim + nc] = grid[r][c];
      end
    end
    return y;
  endfunction

  function automatic int dim_of(input int id);   return (id == 2) ? 5 : 8; endfunction
  function automatic int lanes_of(input int id); return (id == 0) ? 1 : (id == 1) ? 4 : 5; endfunction

  function automatic logic done_of(input int id);
    return (id == 0) ? done_a : (id == 1) ? done_b : done_c;
  endfunction
  function automatic logic busy_of(input int id);
    return (id == 0) ? busy_a : (id == 1) ? busy_b : busy_c;
  endfunction
  function automatic int cnt_of(input int id);
    return (id == 0) ? int'(cnt_a) : (id == 1) ? int'(cnt_b) : int'(cnt_c);
  endfunction
  function automatic logic [63:0] out_of(input int id);
    return (id == 0) ? out_a : (id == 1) ? out_b : {39'b0, out_c};
  endfunction

  // ---------------- drivers ----------------
  task automatic drive(input int id, input logic s, input logic [1:0] m, input logic [63:0] x);
    case (id)
      0:       begin start_a = s; mode_a = m; in_a = x; end
      1:       begin start_b = s; mode_b = m; in_b = x; end
      default: begin start_c = s; mode_c = m; in_c = x[24:0]; end
    endcase
  endtask

  task automatic set_start(input int id, input logic s);
    case (id)
      0:       start_a = s;
      1:       start_b = s;
      default: start_c = s;
    endcase
  endtask

  // inject: 0 plain run, 1 extra start pulse at cnt==10, 2 reset at cnt==20
  task automatic run(input int id, input logic [1:0] m, input logic [63:0] x,
                     input int inject, output logic [63:0] res);
    int edges;
    logic injected;
    logic [63:0] want;
    exp_q.push_back(model(dim_of(id), int'(m), x));
    res = '0;
    @(negedge clk);
    drive(id, 1'b1, m, x);
    @(posedge clk); #1;
    // scramble inputs after capture; the engine must ignore them
    drive(id, 1'b0, 2'($urandom_range(0, 3)), {$urandom, $urandom});
    edges = 1;
    injected = 1'b0;
    check("busy_run", 64'(busy_of(id)), 64'd1);
    while (!done_of(id) && edges < 300) begin
      if (inject == 1 && !injected && cnt_of(id) == 10) begin
        set_start(id, 1'b1);
        injected = 1'b1;
      end else begin
        set_start(id, 1'b0);
      end
      if (inject == 2 && cnt_of(id) == 20) begin
        rst = 1'b0;
        #1;
        check("rst_busy", 64'(busy_of(id)), 64'd0);
        check("rst_cnt",  64'(cnt_of(id)),  64'd0);
        check("rst_out",  out_of(id),       64'd0);
        @(negedge clk);
        rst = 1'b1;
        void'(exp_q.pop_back());
        return;
      end
      @(posedge clk); #1;
      edges++;
    end
    set_start(id, 1'b0);
    check("latency", 64'(edges), 64'((dim_of(id) * dim_of(id)) / lanes_of(id) + 1));
    want = exp_q.pop_front();
    res = out_of(id);
    check("result", res, want);
    @(posedge clk); #1;
    check("done_pulse", 64'(done_of(id)), 64'd0);
    check("idle_busy",  64'(busy_of(id)), 64'd0);
    check("hold",       out_of(id),       want);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [63:0] x, res, res2;
    rst = 1'b0;
    drive(0, 1'b0, 2'd0, 64'd0);
    drive(1, 1'b0, 2'd0, 64'd0);
    drive(2, 1'b0, 2'd0, 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_out",  out_a,        64'd0);
    check("reset_busy", 64'(busy_a),  64'd0);
    check("reset_done", 64'(done_a),  64'd0);
    check("reset_cnt",  64'(cnt_a),   64'd0);
    check("reset_out5", {39'b0, out_c}, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    run(0, 2'd0, 64'h2, 0, res);
    check("m0_directed", res, 64'h100);
    run(0, 2'd1, 64'h1, 0, res);
    check("m1_directed", res, 64'h80);
    run(0, 2'd2, 64'h1, 0, res);
    check("m2_directed", res, 64'h8000_0000_0000_0000);
    for (int t = 0; t < 8; t++) run(0, 2'(t % 4), {$urandom, $urandom}, 0, res);

    x = {$urandom, $urandom};
    run(1, 2'd3, x, 0, res);
    run(1, 2'd3, res, 0, res2);
    check("mirror_twice", res2, x);
    for (int t = 0; t < 4; t++) run(1, 2'(t), {$urandom, $urandom}, 0, res);

    run(0, 2'd1, {$urandom, $urandom}, 1, res);

    x = {$urandom, $urandom};
    run(0, 2'd2, x, 2, res);
    run(0, 2'd2, x, 0, res);

    for (int t = 0; t < 4; t++) run(2, 2'(t), {39'b0, 25'($urandom)}, 0, res);
    for (int t = 0; t < 4; t++) begin
      run(2, 2'(t), 64'h1FF_FFFF, 0, res);
      check("all_ones5", res, 64'h1FF_FFFF);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
